lif_pool: RTL

- Parametrised bank of NUM_CH first-order leaky integrate-and-fire neurons, all advancing together on each input time step.
- Generalises the single 8-bit LIF neuron:
  - configurable membrane width and leak rate (beta = 1 - 2^-BETA_SHIFT);
  - runtime threshold, selectable subtract/zero reset, per-channel refractory period;
  - saturating arithmetic and a valid strobe.
- Sits between the input current encoder and the spike router.

---
 rtl/lif_pool.sv | 89 ++++++++
 1 files changed

// File: rtl/lif_pool.sv
// Bank of NUM_CH leaky integrate-and-fire neurons sharing one time-step strobe.
// Optional per-channel saturating spike counters: define LIF_POOL_SPIKE_COUNT_EN.
module lif_pool #(
    parameter int NUM_CH     = 4,
    parameter int W          = 8,
    parameter int BETA_SHIFT = 1,
    parameter int REFRAC     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [NUM_CH*W-1:0]  current,
    input  logic [W-1:0]         thr,
    input  logic                 reset_mode,
`ifdef LIF_POOL_SPIKE_COUNT_EN
    input  logic                 cnt_clr,
    output logic [NUM_CH*16-1:0] spk_cnt,
`endif
    output logic                 out_valid,
    output logic [NUM_CH-1:0]    spike,
    output logic [NUM_CH*W-1:0]  mem
);

    localparam int RW = 4;

    logic [RW-1:0]     refr      [NUM_CH];
    logic [RW-1:0]     next_refr [NUM_CH];
    logic [W-1:0]      leak      [NUM_CH];
    logic [W:0]        sum       [NUM_CH];
    logic [W-1:0]      sat       [NUM_CH];
    logic [W-1:0]      next_mem  [NUM_CH];
    logic [NUM_CH-1:0] fire;

    // The leak never underflows because U >> k <= U; the sum gets one extra bit for saturation.
    always_comb begin
        fire = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            leak[c] = mem[c*W +: W] - (mem[c*W +: W] >> BETA_SHIFT);
            sum[c]  = {1'b0, leak[c]} + {1'b0, current[c*W +: W]};
            sat[c]  = sum[c][W] ? {W{1'b1}} : sum[c][W-1:0];
            if (refr[c] != '0) begin
                next_refr[c] = refr[c] - 1'b1;
                next_mem[c]  = leak[c];
            end else begin
                fire[c]      = (thr != '0) && (sat[c] >= thr);
                next_refr[c] = fire[c] ? RW'(REFRAC) : '0;
                if (!fire[c])
                    next_mem[c] = sat[c];
                else if (reset_mode)
                    next_mem[c] = '0;
                else
                    next_mem[c] = sat[c] - thr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            spike     <= '0;
            mem       <= '0;
            for (int c = 0; c < NUM_CH; c++)
                refr[c] <= '0;
        end else begin
            out_valid <= in_valid;
            spike     <= in_valid ? fire : '0;
            if (in_valid) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    mem[c*W +: W] <= next_mem[c];
                    refr[c]       <= next_refr[c];
                end
            end
        end
    end

`ifdef LIF_POOL_SPIKE_COUNT_EN
    // A clear on the same edge as a spike wins over the increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            spk_cnt <= '0;
        end else if (in_valid) begin
            for (int c = 0; c < NUM_CH; c++)
                if (fire[c] && spk_cnt[c*16 +: 16] != 16'hFFFF)
                    spk_cnt[c*16 +: 16] <= spk_cnt[c*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule
